bfp_norm_ctrl: RTL and testbench
================================

BFP_NORM_CTRL -- requirements
Module: bfp_norm_ctrl

Interface
REQ-001 SHALL have parameter INPUT_SIZE, default 16, meaning width of one FP16 input word.
REQ-002 SHALL have parameter EXPONENT_SIZE, default 5, meaning exponent field width.
REQ-003 SHALL have parameter MANTISSA_SIZE, default 10, meaning mantissa field width.
REQ-004 SHALL have parameter BLOCK_LEN, default 4, meaning number of elements sharing one exponent.
REQ-005 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-007 SHALL have port in_valid, input, 1, in_data is valid.
REQ-008 SHALL have port in_ready, output, 1, block accepts in_data this cycle.
REQ-009 SHALL have port in_data, input, INPUT_SIZE, FP16 word {sign, exponent, mantissa}.
REQ-010 SHALL have port flush, input, 1, single-cycle pulse that closes a partial block.
REQ-011 SHALL have port out_valid, output, 1, block result is valid.
REQ-012 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-013 SHALL have port out_man, output, BLOCK_LEN*(MANTISSA_SIZE+1), lanes of {sign, shifted mantissa}; lane 0 in the LSBs.
REQ-014 SHALL have port out_exp, output, EXPONENT_SIZE, shared block exponent.
REQ-015 SHALL have port busy, output, 1, high in any state other than FILL with zero elements held.

Function
REQ-016 SHALL implement the FSM states FILL, MAX, SHIFT and EMIT.
REQ-017 SHALL drive in_ready=1 only in FILL; an element is accepted when in_valid and in_ready are both high, and it is stored in lane = count, count++.
REQ-018 SHALL move from FILL to MAX on the edge that accepts element BLOCK_LEN-1.
REQ-019 SHALL, in MAX, seed max with lane 0 exponent and compare one further lane per cycle, spending BLOCK_LEN-1 cycles, then move to SHIFT.
REQ-020 SHALL, in SHIFT, register each lane as {sign, mantissa >> (max - exp_lane)} and out_exp=max in one cycle, then move to EMIT.
REQ-021 SHALL give a shift amount >= MANTISSA_SIZE a zero mantissa; the sign SHALL be kept; comparisons SHALL be unsigned on the raw exponent field.
REQ-022 SHALL assert out_valid exactly BLOCK_LEN+1 cycles after the edge that accepted the final element.
REQ-023 SHALL hold out_valid, out_man and out_exp stable in EMIT until out_ready=1; on that edge it SHALL return to FILL with count=0.
REQ-024 SHALL, when flush=1 in FILL with count>=1, zero-pad the remaining lanes (word 0x0000) and enter MAX.
REQ-025 SHALL ignore flush when count=0 and outside FILL.
REQ-026 SHALL, when flush and an accepted in_valid occur together, store the element first and then pad.
REQ-027 SHALL accept no input outside FILL, because in_ready=0 there.

Reset
REQ-028 SHALL, with rst_n=0 at a clock edge, set state=FILL, count=0, out_valid=0, out_man=0, out_exp=0, busy=0 and in_ready=1 on the next cycle, discarding any partial or pending block.
REQ-029 SHALL apply reset in any state, including while EMIT is waiting on out_ready; a pending result is lost.

Configuration
REQ-030 SHALL compile in, when BFP_STICKY_EN is defined, an output port inexact (1 bit), valid with out_valid, high if any lane shifted out a nonzero mantissa bit; it SHALL reset to 0.
REQ-031 SHALL, when BFP_STICKY_EN is undefined, have no inexact port and no sticky logic; all other behaviour is identical.

Structure
REQ-032 SHALL place the default parameters, field-slice constants and the FSM state typedef in shared package bfp_pkg.
REQ-033 SHALL use one sub-module, bfp_lane_shift: a combinational per-lane shifter with saturation to zero and a sticky output, instantiated BLOCK_LEN times.

Verification
REQ-034 SHALL test in_data 0x3C00,0x4200,0x3E00,0x4400, then out_ready=1: out_exp=0x11 and lanes 0..3 = 0x000,0x100,0x080,0x000, with out_valid rising 5 cycles after the last accept.
REQ-035 SHALL test 0xBC00,0x3C00,0x3C00,0x3C00: lane 0 = 0x400 and out_exp=0x0F.
REQ-036 SHALL test 0x4200, 0x3E00, then flush: lanes 2..3 = 0x000, out_exp=0x10, lane 0 = 0x200, lane 1 = 0x100.
REQ-037 SHALL test out_ready held 0 for 10 cycles in EMIT: outputs stable and in_ready=0 throughout.
REQ-038 SHALL test rst_n=0 for one cycle during MAX: out_valid=0, count=0 and in_ready=1 on the next cycle, then a fresh block completes correctly.
REQ-039 SHALL test, with BFP_STICKY_EN defined, 0x3C01,0x4400,0x4400,0x4400: inexact=1; with 0x3C00 in lane 0: inexact=0.

Source files
------------

// File: rtl/bfp_pkg.sv
// Shared definitions for the block-floating-point normaliser.
// Holds the default FP16 field widths, the field-slice positions for that
// default format and the controller state encoding. Build option
// BFP_STICKY_EN (used by bfp_lane_shift and bfp_norm_ctrl) adds the
// inexact/sticky path; it does not change anything in this package.
package bfp_pkg;

  localparam int BFP_INPUT_SIZE    = 16;
  localparam int BFP_EXPONENT_SIZE = 5;
  localparam int BFP_MANTISSA_SIZE = 10;
  localparam int BFP_BLOCK_LEN     = 4;

  // Field positions inside one default-format word {sign, exponent, mantissa}
  localparam int BFP_MAN_LSB  = 0;
  localparam int BFP_EXP_LSB  = BFP_MANTISSA_SIZE;
  localparam int BFP_SIGN_BIT = BFP_MANTISSA_SIZE + BFP_EXPONENT_SIZE;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_MAX   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_EMIT  = 2'd3
  } bfp_state_t;

endpackage

// File: rtl/bfp_lane_shift.sv
// Combinational per-lane aligner: shifts one element's mantissa right by
// (block max exponent - element exponent) and keeps the sign.
// Shift amounts of MANTISSA_SIZE or more saturate the mantissa to zero.
// Ports:
//   i_word   - stored element {sign, exponent, mantissa}
//   i_max    - shared block exponent (always >= this element's exponent)
//   o_lane   - {sign, aligned mantissa}
//   o_sticky - (only with BFP_STICKY_EN) a nonzero mantissa bit was lost
module bfp_lane_shift
  import bfp_pkg::*;
#(
  parameter int INPUT_SIZE    = BFP_INPUT_SIZE,
  parameter int EXPONENT_SIZE = BFP_EXPONENT_SIZE,
  parameter int MANTISSA_SIZE = BFP_MANTISSA_SIZE
) (
  input  logic [INPUT_SIZE-1:0]    i_word,
  input  logic [EXPONENT_SIZE-1:0] i_max,
  output logic [MANTISSA_SIZE:0]   o_lane
`ifdef BFP_STICKY_EN
  ,
  output logic                     o_sticky
`endif
);

  localparam int EXP_LSB  = MANTISSA_SIZE;
  localparam int SIGN_BIT = MANTISSA_SIZE + EXPONENT_SIZE;

  logic [EXPONENT_SIZE-1:0] w_amt;
  logic [MANTISSA_SIZE-1:0] w_man;
  logic [MANTISSA_SIZE-1:0] w_shifted;
  logic                     w_sat;

  assign w_man = i_word[MANTISSA_SIZE-1:0];
  // Exponent fields are compared as raw unsigned values, so max - exp never wraps
  assign w_amt = i_max - i_word[EXP_LSB +: EXPONENT_SIZE];
  assign w_sat = ({{(32-EXPONENT_SIZE){1'b0}}, w_amt} >= 32'(MANTISSA_SIZE));

  assign w_shifted = w_sat ? '0 : (w_man >> w_amt);
  assign o_lane    = {i_word[SIGN_BIT], w_shifted};

`ifdef BFP_STICKY_EN
  logic [MANTISSA_SIZE-1:0] w_lost_mask;
  // Bits below the shift amount fall off the end; saturation loses them all
  assign w_lost_mask = w_sat ? '1 : ~({MANTISSA_SIZE{1'b1}} << w_amt);
  assign o_sticky    = |(w_man & w_lost_mask);
`endif

endmodule

// File: rtl/bfp_norm_ctrl.sv
// Block-floating-point normaliser controller.
// Collects BLOCK_LEN FP16 words, finds the largest raw exponent one lane per
// cycle, then aligns every mantissa to it and presents the block with a
// single shared exponent until the consumer takes it.
//   state  | meaning
//   FILL   | accepting words into lane = count; flush closes a partial block
//   MAX    | scanning lanes 1..BLOCK_LEN-1 for the largest exponent
//   SHIFT  | registering aligned lanes and the shared exponent
//   EMIT   | out_valid held with stable data until out_ready
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready/in_data input
// handshake, flush, out_valid/out_ready/out_man/out_exp result handshake,
// busy, and inexact when built with BFP_STICKY_EN defined.
module bfp_norm_ctrl
  import bfp_pkg::*;
#(
  parameter int INPUT_SIZE    = BFP_INPUT_SIZE,
  parameter int EXPONENT_SIZE = BFP_EXPONENT_SIZE,
  parameter int MANTISSA_SIZE = BFP_MANTISSA_SIZE,
  parameter int BLOCK_LEN     = BFP_BLOCK_LEN
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [INPUT_SIZE-1:0]                 in_data,
  input  logic                                  flush,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [BLOCK_LEN*(MANTISSA_SIZE+1)-1:0] out_man,
  output logic [EXPONENT_SIZE-1:0]              out_exp,
  output logic                                  busy
`ifdef BFP_STICKY_EN
  ,
  output logic                                  inexact
`endif
);

  localparam int LANE_W  = MANTISSA_SIZE + 1;
  localparam int CNT_W   = (BLOCK_LEN > 1) ? $clog2(BLOCK_LEN) : 1;
  localparam int EXP_LSB = MANTISSA_SIZE;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BLOCK_LEN - 1);

  bfp_state_t                  r_state;
  logic [CNT_W-1:0]            r_count;
  logic [CNT_W-1:0]            r_idx;
  logic [EXPONENT_SIZE-1:0]    r_max;
  logic [INPUT_SIZE-1:0]       r_lane [BLOCK_LEN];
  logic                        r_in_ready;
  logic                        r_busy;
  logic                        r_out_valid;
  logic [BLOCK_LEN*LANE_W-1:0] r_out_man;
  logic [EXPONENT_SIZE-1:0]    r_out_exp;

  logic [BLOCK_LEN*LANE_W-1:0] w_shifted;
  logic [EXPONENT_SIZE-1:0]    w_idx_exp;
  logic                        w_accept;
  logic                        w_close;

  // in_ready is only ever high in FILL, so an accept implies FILL
  assign w_accept  = in_valid && r_in_ready;
  // A flush with nothing held is ignored; a flush with an accept closes after storing it
  assign w_close   = (r_state == ST_FILL) &&
                     ((w_accept && (r_count == LAST_IDX)) || (flush && (r_count != '0)));
  assign w_idx_exp = r_lane[r_idx][EXP_LSB +: EXPONENT_SIZE];

`ifdef BFP_STICKY_EN
  logic [BLOCK_LEN-1:0] w_sticky;
  logic                 r_inexact;
`endif

  for (genvar g = 0; g < BLOCK_LEN; g++) begin : g_lane
    bfp_lane_shift #(
      .INPUT_SIZE    (INPUT_SIZE),
      .EXPONENT_SIZE (EXPONENT_SIZE),
      .MANTISSA_SIZE (MANTISSA_SIZE)
    ) u_shift (
      .i_word   (r_lane[g]),
      .i_max    (r_max),
      .o_lane   (w_shifted[g*LANE_W +: LANE_W])
`ifdef BFP_STICKY_EN
      ,
      .o_sticky (w_sticky[g])
`endif
    );
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_FILL;
      r_count     <= '0;
      r_idx       <= '0;
      r_max       <= '0;
      r_in_ready  <= 1'b1;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_man   <= '0;
      r_out_exp   <= '0;
      for (int i = 0; i < BLOCK_LEN; i++) r_lane[i] <= '0;
`ifdef BFP_STICKY_EN
      r_inexact   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_FILL: begin
          if (w_accept) begin
            r_lane[r_count] <= in_data;
            r_count         <= r_count + 1'b1;
            r_busy          <= 1'b1;
          end
          // Unwritten lanes are still zero from the last clear, which is the flush pad
          if (w_close) begin
            r_state    <= ST_MAX;
            r_in_ready <= 1'b0;
            r_max      <= r_lane[0][EXP_LSB +: EXPONENT_SIZE];
            r_idx      <= CNT_W'(1);
          end
        end
        ST_MAX: begin
          if (w_idx_exp > r_max) r_max <= w_idx_exp;
          if (r_idx == LAST_IDX) r_state <= ST_SHIFT;
          else                   r_idx   <= r_idx + 1'b1;
        end
        ST_SHIFT: begin
          r_out_man   <= w_shifted;
          r_out_exp   <= r_max;
          r_out_valid <= 1'b1;
          r_state     <= ST_EMIT;
`ifdef BFP_STICKY_EN
          r_inexact   <= |w_sticky;
`endif
        end
        ST_EMIT: begin
          if (out_ready) begin
            r_state     <= ST_FILL;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_count     <= '0;
            for (int i = 0; i < BLOCK_LEN; i++) r_lane[i] <= '0;
          end
        end
        default: r_state <= ST_FILL;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_man   = r_out_man;
  assign out_exp   = r_out_exp;
`ifdef BFP_STICKY_EN
  assign inexact   = r_inexact;
`endif

endmodule

// File: tb/tb_bfp_norm_ctrl.sv
module tb_bfp_norm_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [43:0] out_man;
  logic [4:0]  out_exp;
  logic        busy;
`ifdef BFP_STICKY_EN
  logic        inexact;
`endif

  bfp_norm_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_man   (out_man),
    .out_exp   (out_exp),
    .busy      (busy)
`ifdef BFP_STICKY_EN
    ,
    .inexact   (inexact)
`endif
  );

  always #5 clk = ~clk;

  // fmode: 0 = full block, 1 = separate flush cycle after words, 2 = flush with last word
  typedef struct {
    logic [3:0][15:0] w;
    int               n;
    int               fmode;
    logic [3:0][10:0] lane;
    logic [4:0]       ex;
    logic             inx;
  } vec_t;

  typedef struct {
    logic [3:0][10:0] lane;
    logic [4:0]       ex;
    logic             inx;
  } exp_t;

  localparam int NV = 8;
  vec_t vt [NV];
  exp_t sb [$];

  int n_total = 0;
  int n_pass  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
  endtask

  task automatic set_vec(input int k, input logic [15:0] w0, w1, w2, w3, input int n,
                         input int fmode, input logic [10:0] l0, l1, l2, l3,
                         input logic [4:0] ex, input logic inx);
    vt[k].w[0] = w0; vt[k].w[1] = w1; vt[k].w[2] = w2; vt[k].w[3] = w3;
    vt[k].n = n; vt[k].fmode = fmode;
    vt[k].lane[0] = l0; vt[k].lane[1] = l1; vt[k].lane[2] = l2; vt[k].lane[3] = l3;
    vt[k].ex = ex; vt[k].inx = inx;
  endtask

  // Returns on the falling edge right after the closing edge (cycle 1 of MAX)
  task automatic send_block(input int k, input bit push);
    exp_t e;
    for (int i = 0; i < vt[k].n; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vt[k].w[i];
      flush    = (vt[k].fmode == 2) && (i == vt[k].n - 1);
    end
    if (vt[k].fmode == 1) begin
      @(negedge clk);
      in_valid = 1'b0;
      flush    = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    in_data  = '0;
    if (push) begin
      e.lane = vt[k].lane;
      e.ex   = vt[k].ex;
      e.inx  = vt[k].inx;
      sb.push_back(e);
    end
  endtask

  task automatic wait_valid(output int cyc_o);
    int cyc = 1;
    while (!out_valid && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    cyc_o = cyc;
  endtask

  task automatic compare_out(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      for (int i = 0; i < 4; i++)
        chk($sformatf("%s_lane%0d", tag, i), 64'(out_man[i*11 +: 11]), 64'(e.lane[i]));
      chk({tag, "_exp"}, 64'(out_exp), 64'(e.ex));
`ifdef BFP_STICKY_EN
      chk({tag, "_inexact"}, 64'(inexact), 64'(e.inx));
`endif
    end
    chk({tag, "_emit_ready_busy"}, {62'd0, in_ready, busy}, 64'b01);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_after_release"}, {61'd0, out_valid, in_ready, busy}, 64'b010);
  endtask

  task automatic run_vec(input int k);
    int    cyc;
    string tag;
    tag = $sformatf("v%0d", k);
    send_block(k, 1'b1);
    wait_valid(cyc);
    chk({tag, "_valid_seen"}, 64'(out_valid), 64'd1);
    chk({tag, "_latency"}, 64'(cyc), 64'd5);
    compare_out(tag);
    release_out(tag);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1);
  end

  initial begin
    int   cyc;
    int   nv;
    exp_t e;

    //        words                                 n  fm  lanes 0..3                          exp    inx
    set_vec(0, 16'h3C00, 16'h4200, 16'h3E00, 16'h4400, 4, 0, 11'h000, 11'h100, 11'h080, 11'h000, 5'h11, 1'b0);
    set_vec(1, 16'hBC00, 16'h3C00, 16'h3C00, 16'h3C00, 4, 0, 11'h400, 11'h000, 11'h000, 11'h000, 5'h0F, 1'b0);
    set_vec(2, 16'h4200, 16'h3E00, 16'h0000, 16'h0000, 2, 1, 11'h200, 11'h100, 11'h000, 11'h000, 5'h10, 1'b0);
    set_vec(3, 16'h4600, 16'h4200, 16'h0000, 16'h0000, 2, 2, 11'h200, 11'h100, 11'h000, 11'h000, 5'h11, 1'b0);
    set_vec(4, 16'h3C01, 16'h4400, 16'h4400, 16'h4400, 4, 0, 11'h000, 11'h000, 11'h000, 11'h000, 5'h11, 1'b1);
    set_vec(5, 16'h3C00, 16'h4400, 16'h4400, 16'h4400, 4, 0, 11'h000, 11'h000, 11'h000, 11'h000, 5'h11, 1'b0);
    set_vec(6, 16'h7BFF, 16'h03FF, 16'h83FF, 16'h7800, 4, 0, 11'h3FF, 11'h000, 11'h400, 11'h000, 5'h1E, 1'b1);
    set_vec(7, 16'h5000, 16'h2BFF, 16'h2FFF, 16'h5000, 4, 0, 11'h000, 11'h000, 11'h001, 11'h000, 5'h14, 1'b1);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_state", {11'd0, out_valid, in_ready, busy, out_exp, out_man},
        {11'd0, 1'b0, 1'b1, 1'b0, 5'h00, 44'h0});

    for (int k = 0; k < NV; k++) run_vec(k);

    // flush with nothing held must not start a block
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    chk("flush_empty_ignored", {62'd0, in_ready, busy}, 64'b10);
    repeat (6) @(negedge clk);
    chk("flush_empty_no_output", {62'd0, out_valid, in_ready}, 64'b01);

    // EMIT stall: outputs frozen and no input taken while out_ready stays low
    send_block(0, 1'b1);
    wait_valid(cyc);
    chk("stall_valid_seen", 64'(out_valid), 64'd1);
    e = sb.pop_front();
    in_valid = 1'b1;
    in_data  = 16'h7C00;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk($sformatf("stall_c%0d", c), {12'd0, out_valid, in_ready, busy, out_exp, out_man},
          {12'd0, 1'b1, 1'b0, 1'b1, e.ex, e.lane});
    end
    in_valid = 1'b0;
    in_data  = '0;
    release_out("stall");
    run_vec(1);

    // reset during MAX discards the block
    send_block(1, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_max_state", {61'd0, out_valid, in_ready, busy}, 64'b010);
    nv = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) nv++;
    end
    chk("rst_max_no_output", 64'(nv), 64'd0);
    run_vec(0);

    // reset while EMIT waits: pending result lost
    send_block(6, 1'b0);
    wait_valid(cyc);
    chk("rst_emit_valid_seen", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_emit_state", {11'd0, out_valid, in_ready, busy, out_exp, out_man},
        {11'd0, 1'b0, 1'b1, 1'b0, 5'h00, 44'h0});
    run_vec(2);

    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
